// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a parallel word out on x, MSB first,
// one bit per clock, framed by a start/busy/done handshake.
module serial_pattern_tx #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0,
    localparam int  LW         = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [LW-1:0]    len,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [LW-1:0]    cnt, cnt_n;
    logic             x_n, x_valid_n, busy_n, done_n;
    logic [LW-1:0]    eff_len;

    // A length of zero or anything beyond the register width means "send everything".
    assign eff_len = ((len == '0) || (len > LW'(WIDTH))) ? LW'(WIDTH) : len;

    // NOTE: every output is registered here so x is glitch-free; the comb block only computes next values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            shreg   <= '0;
            cnt     <= '0;
            x       <= IDLE_LEVEL;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: non-blocking so all state updates see the same pre-edge values.
            state   <= state_n;
            shreg   <= shreg_n;
            cnt     <= cnt_n;
            x       <= x_n;
            x_valid <= x_valid_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    always_comb begin
        // NOTE: hold-everything defaults first, so no path through the case infers a latch.
        state_n   = state;
        shreg_n   = shreg;
        cnt_n     = cnt;
        x_n       = x;
        x_valid_n = x_valid;
        busy_n    = busy;
        done_n    = done;

        unique case (state)
            S_IDLE: begin
                x_n       = IDLE_LEVEL;
                x_valid_n = 1'b0;
                busy_n    = 1'b0;
                done_n    = 1'b0;
                if (start) begin
                    // First bit goes out on the accept edge; cnt holds the bits still to follow.
                    x_n       = data[WIDTH-1];
                    x_valid_n = 1'b1;
                    busy_n    = 1'b1;
                    shreg_n   = {data[WIDTH-2:0], 1'b0};
                    cnt_n     = eff_len - 1'b1;
                    state_n   = S_SEND;
                end
            end

            S_SEND: begin
                if (cnt == '0) begin
                    x_n       = IDLE_LEVEL;
                    x_valid_n = 1'b0;
                    busy_n    = 1'b0;
                    done_n    = 1'b1;
                    state_n   = S_DONE;
                end else begin
                    x_n     = shreg[WIDTH-1];
                    shreg_n = {shreg[WIDTH-2:0], 1'b0};
                    cnt_n   = cnt - 1'b1;
                end
            end

            S_DONE: begin
                done_n  = 1'b0;
                state_n = S_IDLE;
            end

            default: begin
                state_n   = S_IDLE;
                x_n       = IDLE_LEVEL;
                x_valid_n = 1'b0;
                busy_n    = 1'b0;
                done_n    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: hand-computed bit streams, len clamping,
// start-during-send immunity, back-to-back spacing and async reset mid-pattern.
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data = '0;
    logic [3:0] len = '0;
    logic       x, x_valid, busy, done;

    int n_checks = 0;
    int n_errors = 0;

    serial_pattern_tx #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data    (data),
        .len     (len),
        .x       (x),
        .x_valid (x_valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".x"}, x, 1'b0);
        check({tag, ".x_valid"}, x_valid, 1'b0);
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".done"}, done, 1'b0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
    task automatic send(input string tag, input logic [7:0] d, input logic [3:0] l,
                        input logic [7:0] bits, input int n);
        start = 1'b1; data = d; len = l;
        @(negedge clk);
        start = 1'b0; data = ~d; len = 4'd1;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s.bit%0d", tag, k), x, bits[7-k]);
            check($sformatf("%s.valid%0d", tag, k), x_valid, 1'b1);
            check($sformatf("%s.busy%0d", tag, k), busy, 1'b1);
            check($sformatf("%s.nodone%0d", tag, k), done, 1'b0);
            @(negedge clk);
        end
        check({tag, ".done"}, done, 1'b1);
        check({tag, ".done_x"}, x, 1'b0);
        check({tag, ".done_valid"}, x_valid, 1'b0);
        check({tag, ".done_busy"}, busy, 1'b0);
        @(negedge clk);
        check_idle({tag, ".after"});
    endtask

    initial begin
        // 1. Held in reset with random stimulus
        for (int i = 0; i < 6; i++) begin
            start = 1'($urandom);
            data  = 8'($urandom);
            len   = 4'($urandom);
            @(negedge clk);
            check_idle($sformatf("rst%0d", i));
        end
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_idle("post_rst");

        // 2. Full 8-bit pattern
        send("p79", 8'b0111_1001, 4'd8, 8'b0111_1001, 8);

        // 3. Short and clamped lengths (back-to-back at earliest accept)
        send("len3",  8'b1010_0000, 4'd3,  8'b1010_0000, 3);
        send("len0",  8'b1100_1010, 4'd0,  8'b1100_1010, 8);
        send("len15", 8'b1001_0110, 4'd15, 8'b1001_0110, 8);
        send("len1",  8'b1000_0000, 4'd1,  8'b1000_0000, 1);

        // 4. start held, data changed mid-send; re-accept only after DONE + IDLE
        start = 1'b1; data = 8'h0F; len = 4'd8;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (k == 2) data = 8'hFF;
            check($sformatf("hold.bit%0d", k), x, (k >= 4) ? 1'b1 : 1'b0);
            check($sformatf("hold.valid%0d", k), x_valid, 1'b1);
            @(negedge clk);
        end
        check("hold.done", done, 1'b1);
        check("hold.gap0_x", x, 1'b0);
        check("hold.gap0_valid", x_valid, 1'b0);
        @(negedge clk);
        check("hold.gap1_x", x, 1'b0);
        check("hold.gap1_valid", x_valid, 1'b0);
        check("hold.gap1_done", done, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("hold.next_bit0", x, 1'b1);
        check("hold.next_valid", x_valid, 1'b1);
        check("hold.next_busy", busy, 1'b1);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("hold.next_bit%0d", k), x, 1'b1);
        end
        @(negedge clk);
        check("hold.next_done", done, 1'b1);
        @(negedge clk);
        check_idle("hold.idle");

        // 5. Async reset after three bits
        start = 1'b1; data = 8'b1110_0000; len = 4'd8;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("mid.bit%0d", k), x, 1'b1);
            if (k < 2) @(negedge clk);
        end
        #2 reset = 1'b0;
        #1;
        check("mid.async_x", x, 1'b0);
        check("mid.async_valid", x_valid, 1'b0);
        check("mid.async_busy", busy, 1'b0);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle($sformatf("mid.held%0d", i));
        end
        reset = 1'b1;
        start = 1'b0;
        send("after_rst", 8'b1010_0101, 4'd0, 8'b1010_0101, 8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
